// File: rtl/int_mac_pipe.sv
// int_mac_pipe: pipelined signed/unsigned integer multiply-accumulate unit.
// Stage 1 forms an exact sign-magnitude product, stages 2..N_STAGES-1 delay
// it, and the final stage accumulates into a saturating W_ACC-bit signed
// accumulator, emitting one registered result per first..last group.
module int_mac_pipe #(
    parameter int W_IN_A   = 8,
    parameter int W_IN_B   = 16,
    parameter int W_ACC    = 32,
    parameter int N_STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN_A-1:0] in_a,
    input  logic [W_IN_B-1:0] in_b,
    input  logic              in_signed,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_ACC-1:0]  out_acc,
    output logic              out_ovf
);

    localparam int W_PROD = W_IN_A + W_IN_B;
    // Registered stages ahead of the accumulate stage; LAST indexes the one
    // feeding the accumulator.
    localparam int N_REG  = N_STAGES - 1;
    localparam int LAST   = N_REG - 1;

    if (W_ACC < W_PROD + 1) begin : g_bad_w_acc
        $error("int_mac_pipe: W_ACC must be >= W_IN_A+W_IN_B+1");
    end
    if (N_STAGES < 2) begin : g_bad_n_stages
        $error("int_mac_pipe: N_STAGES must be >= 2");
    end

    // Magnitude of operand A; the most negative value maps onto 2^(W-1),
    // which still fits the unsigned operand width.
    function automatic logic [W_IN_A-1:0] mag_a(input logic [W_IN_A-1:0] v,
                                                input logic              neg);
        logic [W_IN_A-1:0] m;
        if (neg) begin
            m = ~v + {{(W_IN_A-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Magnitude of operand B, same rule as operand A.
    function automatic logic [W_IN_B-1:0] mag_b(input logic [W_IN_B-1:0] v,
                                                input logic              neg);
        logic [W_IN_B-1:0] m;
        if (neg) begin
            m = ~v + {{(W_IN_B-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Pipeline state, index 0 is the product stage.
    logic              st_valid_r [N_REG];
    logic [W_PROD-1:0] st_mag_r   [N_REG];
    logic              st_sign_r  [N_REG];
    logic              st_first_r [N_REG];
    logic              st_last_r  [N_REG];

    logic [W_ACC-1:0]  acc_r;
    logic              ovf_r;
    logic              out_valid_r;
    logic [W_ACC-1:0]  out_acc_r;
    logic              out_ovf_r;

    logic              adv_s;
    logic              accept_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [W_IN_A-1:0] a_mag_s;
    logic [W_IN_B-1:0] b_mag_s;
    logic [W_PROD-1:0] prod_s;
    logic              sign_s;
    logic [W_ACC:0]    p_mag_s;
    logic [W_ACC:0]    p_s;
    logic [W_ACC:0]    base_s;
    logic [W_ACC:0]    sum_s;
    logic              sat_s;
    logic [W_ACC-1:0]  acc_next_s;
    logic              ovf_next_s;

    // The whole pipe advances only when the output register can be refilled.
    always_comb begin
        adv_s    = !out_valid_r || out_ready;
        in_ready = adv_s && !rst;
        accept_s = in_valid && in_ready;
    end

    // Stage 1 product: sign-magnitude split, exact unsigned magnitude product.
    always_comb begin
        a_neg_s = in_signed & in_a[W_IN_A-1];
        b_neg_s = in_signed & in_b[W_IN_B-1];
        a_mag_s = mag_a(in_a, a_neg_s);
        b_mag_s = mag_b(in_b, b_neg_s);
        prod_s  = W_PROD'(a_mag_s) * W_PROD'(b_mag_s);
        sign_s  = a_neg_s ^ b_neg_s;
    end

    // Accumulate stage: W_ACC+1-bit sum, clamp on signed overflow, sticky flag.
    always_comb begin
        p_mag_s = {{(W_ACC + 1 - W_PROD){1'b0}}, st_mag_r[LAST]};
        if (st_sign_r[LAST]) begin
            p_s = ~p_mag_s + {{W_ACC{1'b0}}, 1'b1};
        end else begin
            p_s = p_mag_s;
        end
        if (st_first_r[LAST]) begin
            base_s = {(W_ACC + 1){1'b0}};
        end else begin
            base_s = {acc_r[W_ACC-1], acc_r};
        end
        sum_s = base_s + p_s;
        sat_s = sum_s[W_ACC] ^ sum_s[W_ACC-1];
        if (sat_s && sum_s[W_ACC]) begin
            acc_next_s = {1'b1, {(W_ACC-1){1'b0}}};
        end else if (sat_s) begin
            acc_next_s = {1'b0, {(W_ACC-1){1'b1}}};
        end else begin
            acc_next_s = sum_s[W_ACC-1:0];
        end
        if (st_first_r[LAST]) begin
            ovf_next_s = sat_s;
        end else begin
            ovf_next_s = sat_s | ovf_r;
        end
    end

    // Product and delay stages; everything holds while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++) begin
                st_valid_r[i] <= 1'b0;
                st_mag_r[i]   <= {W_PROD{1'b0}};
                st_sign_r[i]  <= 1'b0;
                st_first_r[i] <= 1'b0;
                st_last_r[i]  <= 1'b0;
            end
        end else if (adv_s) begin
            st_valid_r[0] <= accept_s;
            st_mag_r[0]   <= prod_s;
            st_sign_r[0]  <= sign_s;
            st_first_r[0] <= in_first;
            st_last_r[0]  <= in_last;
            for (int i = 1; i < N_REG; i++) begin
                st_valid_r[i] <= st_valid_r[i-1];
                st_mag_r[i]   <= st_mag_r[i-1];
                st_sign_r[i]  <= st_sign_r[i-1];
                st_first_r[i] <= st_first_r[i-1];
                st_last_r[i]  <= st_last_r[i-1];
            end
        end
    end

    // Accumulator and result register; a result is presented only on a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {W_ACC{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_acc_r   <= {W_ACC{1'b0}};
            out_ovf_r   <= 1'b0;
        end else if (adv_s) begin
            if (st_valid_r[LAST]) begin
                acc_r <= acc_next_s;
                ovf_r <= ovf_next_s;
                if (st_last_r[LAST]) begin
                    out_valid_r <= 1'b1;
                    out_acc_r   <= acc_next_s;
                    out_ovf_r   <= ovf_next_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_int_mac_pipe.sv
// Self-checking bench for int_mac_pipe: directed scenarios plus a randomized
// run checked against an arithmetic reference model.
module tb_int_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid25;
    logic        in_ready, in_ready25;
    logic [7:0]  in_a;
    logic [15:0] in_b;
    logic        in_signed, in_first, in_last;
    logic        out_valid, out_valid25;
    logic        out_ready;
    logic [31:0] out_acc;
    logic [24:0] out_acc25;
    logic        out_ovf, out_ovf25;

    int n_tests = 0;
    int n_fail  = 0;

    longint got_acc_q[$];
    bit     got_ovf_q[$];
    longint got25_acc_q[$];
    bit     got25_ovf_q[$];

    int_mac_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf)
    );

    int_mac_pipe #(.W_ACC(25)) dut25 (
        .clk(clk), .rst(rst), .in_valid(in_valid25), .in_ready(in_ready25),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid25), .out_ready(out_ready),
        .out_acc(out_acc25), .out_ovf(out_ovf25)
    );

    always #5 clk = ~clk;

    // Collect every completed output handshake of both instances.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_acc_q.push_back(longint'($signed(out_acc)));
                got_ovf_q.push_back(out_ovf);
            end
            if (out_valid25 && out_ready) begin
                got25_acc_q.push_back(longint'($signed(out_acc25)));
                got25_ovf_q.push_back(out_ovf25);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference MAC: plain integer arithmetic with clamping to the wacc range.
    function automatic void mac_ref(input int wacc, input logic [7:0] a,
                                    input logic [15:0] b, input bit sgn,
                                    input bit first, inout longint acc,
                                    inout bit ovf);
        longint av, bv, sum, hi, lo;
        bit     sat;
        av  = sgn ? longint'($signed(a)) : longint'(a);
        bv  = sgn ? longint'($signed(b)) : longint'(b);
        hi  = (longint'(1) <<< (wacc - 1)) - 1;
        lo  = -(longint'(1) <<< (wacc - 1));
        sum = (first ? 0 : acc) + av * bv;
        sat = 1'b0;
        if (sum > hi) begin sum = hi; sat = 1'b1; end
        if (sum < lo) begin sum = lo; sat = 1'b1; end
        acc = sum;
        ovf = (first ? 1'b0 : ovf) | sat;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_acc_q.delete();
        got_ovf_q.delete();
        got25_acc_q.delete();
        got25_ovf_q.delete();
    endtask

    task automatic wait_got(input int n, input bit use25, input int budget, output bit ok);
        int c = 0;
        while (((use25 ? got25_acc_q.size() : got_acc_q.size()) < n) && c < budget) begin
            step();
            c++;
        end
        repeat (6) step();
        ok = ((use25 ? got25_acc_q.size() : got_acc_q.size()) == n);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_valid25 = 1'b1; out_ready = 1'b1;
        in_a = 8'h01; in_b = 16'h0001; in_signed = 1'b0; in_first = 1'b1; in_last = 1'b1;
        step(); step();
        n_tests++;
        if (out_valid !== 1'b0 || out_acc !== 32'h0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b acc=%h ovf=%0b, want 0/0/0", out_valid, out_acc, out_ovf);
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || in_ready25 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b/%0b, want 0", in_ready, in_ready25);
        end
        step();
        in_valid = 1'b0; in_valid25 = 1'b0; rst = 1'b0;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_valid25 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b/%0b, want 1/0/0", in_ready, out_valid, out_valid25);
        end
    endtask

    task automatic test_latency_signed();
        clear_got();
        in_a = 8'hFD; in_b = 16'd1000; in_signed = 1'b1; in_first = 1'b1; in_last = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_accept: in_ready=%0b, want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early1: out_valid=%0b, want 0", out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early2: out_valid=%0b, want 0", out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_acc !== 32'hFFFFF448 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_result: got valid=%0b acc=%h ovf=%0b, want 1 fffff448 0", out_valid, out_acc, out_ovf);
        end
        step(); step();
    endtask

    task automatic test_corners();
        logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'hFF};
        logic [15:0] tb [3] = '{16'h8000, 16'hFFFF, 16'hFFFF};
        bit          ts [3] = '{1'b1, 1'b1, 1'b0};
        longint      te [3] = '{64'sd4194304, 64'sd1, 64'sd16711425};
        bit ok;
        clear_got();
        out_ready = 1'b1; in_first = 1'b1; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_a = ta[k]; in_b = tb[k]; in_signed = ts[k]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        wait_got(3, 1'b0, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL corners_count: got %0d results, want 3", got_acc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (got_acc_q[k] !== te[k] || got_ovf_q[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL corners_%0d: got acc=%0d ovf=%0b, want %0d 0", k, got_acc_q[k], got_ovf_q[k], te[k]);
                end
            end
        end
    endtask

    task automatic test_group();
        bit ok;
        clear_got();
        out_ready = 1'b1; in_a = 8'd10; in_b = 16'hFFEC; in_signed = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_first = (k == 0); in_last = (k == 3); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        wait_got(1, 1'b0, 50, ok);
        n_tests++;
        if (!ok || got_acc_q[0] !== -64'sd800 || got_ovf_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL group_sum: got %0d results, first acc=%0d, want exactly 1 result of -800",
                     got_acc_q.size(), (got_acc_q.size() > 0) ? got_acc_q[0] : 64'sd0);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        clear_got();
        out_ready = 1'b1; in_valid = 1'b0; in_signed = 1'b1;
        in_a = 8'h80; in_b = 16'h8000;
        for (int k = 0; k < 5; k++) begin
            in_first = (k == 0); in_last = (k == 4); in_valid25 = 1'b1;
            step();
        end
        in_a = 8'h01; in_b = 16'h0001; in_first = 1'b1; in_last = 1'b1;
        step();
        in_valid25 = 1'b0;
        wait_got(2, 1'b1, 50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sat_count: got %0d results, want 2", got25_acc_q.size());
        end else begin
            n_tests++;
            if (got25_acc_q[0] !== 64'sd16777215 || got25_ovf_q[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_clamp: got acc=%0d ovf=%0b, want 16777215 1", got25_acc_q[0], got25_ovf_q[0]);
            end
            n_tests++;
            if (got25_acc_q[1] !== 64'sd1 || got25_ovf_q[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_recover: got acc=%0d ovf=%0b, want 1 0", got25_acc_q[1], got25_ovf_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          i = 0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_acc = 32'h0;
        clear_got();
        in_signed = 1'b0; in_first = 1'b1; in_last = 1'b1; in_b = 16'd2;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (i < 10);
            in_a      = i[7:0];
            @(negedge clk);
            if (prev_hold) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_acc !== prev_acc) begin
                    n_fail++;
                    $display("FAIL bp_hold: got valid=%0b acc=%h, want 1 %h", out_valid, out_acc, prev_acc);
                end
            end
            if (out_valid && !out_ready) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %0b while stalled, want 0", in_ready);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_acc  = out_acc;
            if (in_valid && in_ready) i++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (got_acc_q.size() != 10) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, want 10", got_acc_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_tests++;
                if (got_acc_q[k] !== longint'(2 * k)) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: got %0d, want %0d", k, got_acc_q[k], 2 * k);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        clear_got();
        out_ready = 1'b1; in_signed = 1'b0; in_first = 1'b1; in_last = 1'b1;
        in_a = 8'd5; in_b = 16'd5; in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %0b, want 0", in_ready);
        end
        step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out_valid: got %0b, want 0", out_valid);
        end
        repeat (6) step();
        n_tests++;
        if (got_acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d stale results, want 0", got_acc_q.size());
        end
        clear_got();
        in_a = 8'd2; in_b = 16'd3; in_first = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_got(1, 1'b0, 50, ok);
        n_tests++;
        if (!ok || got_acc_q[0] !== 64'sd6) begin
            n_fail++;
            $display("FAIL midrst_after: got %0d results, first acc=%0d, want exactly 1 result of 6",
                     got_acc_q.size(), (got_acc_q.size() > 0) ? got_acc_q[0] : 64'sd0);
        end
    endtask

    task automatic test_random();
        longint exp_acc_q[$];
        bit     exp_ovf_q[$];
        longint m_acc = 0;
        bit     m_ovf = 1'b0;
        bit     force_first = 1'b1;
        bit     ok;
        clear_got();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 16'($urandom);
            in_signed = 1'($urandom);
            in_first  = force_first ? 1'b1 : ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                mac_ref(32, in_a, in_b, in_signed, in_first, m_acc, m_ovf);
                force_first = 1'b0;
                if (in_last) begin
                    exp_acc_q.push_back(m_acc);
                    exp_ovf_q.push_back(m_ovf);
                end
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_got(exp_acc_q.size(), 1'b0, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results, want %0d", got_acc_q.size(), exp_acc_q.size());
        end else begin
            for (int k = 0; k < exp_acc_q.size(); k++) begin
                n_tests++;
                if (got_acc_q[k] !== exp_acc_q[k] || got_ovf_q[k] !== exp_ovf_q[k]) begin
                    n_fail++;
                    $display("FAIL rand_%0d: got acc=%0d ovf=%0b, want %0d %0b",
                             k, got_acc_q[k], got_ovf_q[k], exp_acc_q[k], exp_ovf_q[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid25 = 1'b0; out_ready = 1'b1;
        in_a = 8'h00; in_b = 16'h0000; in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0;
        test_reset();
        test_latency_signed();
        test_corners();
        test_group();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
